alu_regfile_ctrl: RTL and testbench
===================================

# alu_regfile_ctrl

Instruction-issue stage placed directly in front of the `ALU` datapath block. It accepts one instruction per handshake and reads two operands from an internal register file. It drives the ALU's `A`/`B`/`op` inputs, then writes `Y` back to the register file and latches the ALU's `ONZ` flags into a flag register. Load-immediate (op `3'b111`) is executed locally and bypasses the ALU.

## Interface
- `WIDTH`, default 8: data width; must equal the ALU `width`.
- `REGS`, default 8: register count, a power of 2; address width `AW = $clog2(REGS)`.
- `clk` in 1: clock; all state updates on rising edge.
- `rst_n` in 1: reset, asynchronous, active-low.
- `instr_valid` in 1: instruction present.
- `instr_ready` out 1: block can accept an instruction.
- `instr_op` in 3: ALU opcode; `3'b111` = LOADI.
- `instr_rd`, `instr_ra`, `instr_rb` in AW: destination, source A, source B.
- `instr_imm` in WIDTH: immediate, used by LOADI only.
- `alu_a`, `alu_b` out WIDTH: operands to the ALU.
- `alu_op` out 3: opcode to the ALU.
- `alu_y` in WIDTH: ALU result (combinational in the ALU).
- `alu_onz` in 3: ALU flags, {O, N, Z}.
- `flags` out 3: registered {O, N, Z} from the last non-LOADI instruction.
- `wb_valid` out 1: one-cycle pulse when a register is written.
- `wb_addr` out AW, `wb_data` out WIDTH: the write being performed.
- `dbg_addr` in AW, `dbg_data` out WIDTH: combinational register-file read port for benches.

## Operation
- FSM states: IDLE, EXEC, WB.
  - IDLE: `instr_ready=1`. On `instr_valid && instr_ready`, latch op/rd/ra/rb/imm and go to EXEC.
  - EXEC: `alu_a=rf[ra_q]`, `alu_b=rf[rb_q]`, `alu_op=op_q`. At the closing edge:
    - LOADI: `res_q<=imm_q`, flags unchanged.
    - Otherwise: `res_q<=alu_y`, `flags<=alu_onz`.
    - Go to WB.
  - WB: `rf[rd_q]<=res_q` at the closing edge, `wb_valid=1`, go to IDLE.
- `instr_ready` is 0 in EXEC and WB. This structure removes read-after-write hazards, so no forwarding is needed.
- In IDLE and WB, `alu_a`/`alu_b` are 0 and `alu_op` holds `op_q`.
- Every register is writable; register 0 is not hard-wired to zero.
- `ra==rb` is legal. `rd==ra` is legal: the read happens in EXEC and the write in WB.
- Widths:
  - Results are WIDTH bits and are stored verbatim; the block does no arithmetic.
  - `flags` is a copy of `alu_onz`. O/N/Z semantics belong to the ALU: O = signed overflow, N = Y[MSB], Z = (Y==0).

## Timing
- Reset values: state IDLE; all rf entries, `res_q`, `flags`, `wb_*`, `alu_a`, `alu_b`, and `alu_op` are 0. `instr_ready` is forced to 0 while `rst_n=0` and goes to 1 in the first cycle after release.
- Accepting edge k → EXEC during cycle k..k+1 → WB during cycle k+1..k+2. The register is written and `flags` is visible after edge k+1 (flags) or k+2 (rf).
- `instr_ready` returns to 1 after edge k+2. Throughput is one instruction per 3 cycles.
- Asserting `rst_n` low mid-EXEC or mid-WB aborts the instruction: no rf write, and flags are reset.
- `instr_valid` while not ready is ignored. The source must hold its fields until the handshake.

## Structure
- Package `alu_pkg`:
  - Opcode enum: ADD=000, SUB=001, AND=010, OR=011, XOR=100, NOT=101, MOVA=110, LOADI=111.
  - FSM state enum.
  - Flag bit indices: O=2, N=1, Z=0.
- One sub-module, `regfile`: REGS×WIDTH, two combinational read ports plus a debug read port, one synchronous write port, asynchronous active-low reset.
- The bench instantiates `alu_regfile_ctrl` and `ALU` together, connecting `alu_*` ports to the ALU's A, B, op, Y, ONZ.

## Test plan
- Reset: hold `rst_n=0` with random inputs → `instr_ready=0`, `flags=000`, `wb_valid=0`, all `dbg_data` reads 0x00; after release `instr_ready=1`.
- LOADI r1=0x05, then LOADI r2=0x03, then ADD r3=r1+r2 → `wb_valid` pulses 2 cycles after each accept. r3=0x08, `flags=000`, and flags are unchanged by the LOADIs.
- SUB r4=r2−r1 (3−5) → r4=0xFE, `flags=010`.
- LOADI r5=0x7F, LOADI r6=0x01, ADD r7=r5+r6 → r7=0x80, `flags=110`. Then XOR r7=r7^r7 → r7=0x00, `flags=001`.
- Back-to-back: hold `instr_valid=1` with ADD r1=r1+r1 (r1=0x05) for two handshakes → `instr_ready` low for 2 cycles between accepts; r1 goes 0x0A then 0x14.
- Pull `rst_n` low during the EXEC cycle of ADD r3=r1+r2 → `wb_valid` never pulses, r3=0x00, `flags=000`.

Source files
------------

// File: rtl/alu_pkg.sv
// Shared types for the ALU issue stage: opcodes, FSM states and flag bit positions.
package alu_pkg;

    typedef enum logic [2:0] {
        OP_ADD   = 3'b000,
        OP_SUB   = 3'b001,
        OP_AND   = 3'b010,
        OP_OR    = 3'b011,
        OP_XOR   = 3'b100,
        OP_NOT   = 3'b101,
        OP_MOVA  = 3'b110,
        OP_LOADI = 3'b111
    } op_e;

    typedef enum logic [1:0] {
        ST_IDLE = 2'b00,
        ST_EXEC = 2'b01,
        ST_WB   = 2'b10
    } state_e;

    localparam int unsigned FLAG_O = 2;
    localparam int unsigned FLAG_N = 1;
    localparam int unsigned FLAG_Z = 0;

endpackage

// File: rtl/alu_regfile_ctrl_if.sv
// Bundle of instruction, ALU, write-back and debug signals between the issue stage and its neighbours.
interface alu_regfile_ctrl_if #(
    parameter int WIDTH = 8,
    parameter int AW    = 3
);
    logic             instr_valid;
    logic             instr_ready;
    logic [2:0]       instr_op;
    logic [AW-1:0]    instr_rd;
    logic [AW-1:0]    instr_ra;
    logic [AW-1:0]    instr_rb;
    logic [WIDTH-1:0] instr_imm;
    logic [WIDTH-1:0] alu_a;
    logic [WIDTH-1:0] alu_b;
    logic [2:0]       alu_op;
    logic [WIDTH-1:0] alu_y;
    logic [2:0]       alu_onz;
    logic [2:0]       flags;
    logic             wb_valid;
    logic [AW-1:0]    wb_addr;
    logic [WIDTH-1:0] wb_data;
    logic [AW-1:0]    dbg_addr;
    logic [WIDTH-1:0] dbg_data;

    modport master (
        output instr_valid, instr_op, instr_rd, instr_ra, instr_rb, instr_imm,
        output alu_y, alu_onz, dbg_addr,
        input  instr_ready, alu_a, alu_b, alu_op, flags,
        input  wb_valid, wb_addr, wb_data, dbg_data
    );

    modport slave (
        input  instr_valid, instr_op, instr_rd, instr_ra, instr_rb, instr_imm,
        input  alu_y, alu_onz, dbg_addr,
        output instr_ready, alu_a, alu_b, alu_op, flags,
        output wb_valid, wb_addr, wb_data, dbg_data
    );
endinterface

// File: rtl/ALU.sv
// Combinational ALU datapath driven by the issue stage; flags are {O, N, Z}.
module ALU
    import alu_pkg::*;
#(
    parameter int width = 8
) (
    input  logic [width-1:0] A,
    input  logic [width-1:0] B,
    input  logic [2:0]       op,
    output logic [width-1:0] Y,
    output logic [2:0]       ONZ
);
    logic ovf_s;

    // Result and signed-overflow computation per opcode.
    always_comb begin
        Y     = '0;
        ovf_s = 1'b0;
        case (op)
            OP_ADD: begin
                Y     = A + B;
                ovf_s = (A[width-1] == B[width-1]) && (Y[width-1] != A[width-1]);
            end
            OP_SUB: begin
                Y     = A - B;
                ovf_s = (A[width-1] != B[width-1]) && (Y[width-1] != A[width-1]);
            end
            OP_AND:  Y = A & B;
            OP_OR:   Y = A | B;
            OP_XOR:  Y = A ^ B;
            OP_NOT:  Y = ~A;
            OP_MOVA: Y = A;
            default: Y = '0;
        endcase
    end

    // Flag packing.
    always_comb begin
        ONZ         = 3'b000;
        ONZ[FLAG_O] = ovf_s;
        ONZ[FLAG_N] = Y[width-1];
        ONZ[FLAG_Z] = (Y == '0);
    end

endmodule

// File: rtl/regfile.sv
// REGS x WIDTH register file: two combinational read ports, one debug read port, one synchronous write port.
module regfile #(
    parameter int WIDTH = 8,
    parameter int REGS  = 8,
    parameter int AW    = $clog2(REGS)
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             we_i,
    input  logic [AW-1:0]    waddr_i,
    input  logic [WIDTH-1:0] wdata_i,
    input  logic [AW-1:0]    raddr_a_i,
    output logic [WIDTH-1:0] rdata_a_o,
    input  logic [AW-1:0]    raddr_b_i,
    output logic [WIDTH-1:0] rdata_b_o,
    input  logic [AW-1:0]    dbg_addr_i,
    output logic [WIDTH-1:0] dbg_data_o
);
    logic [WIDTH-1:0] mem_q [REGS];

    // Storage array: cleared on reset, single write per cycle.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < REGS; i++) begin
                mem_q[i] <= '0;
            end
        end else if (we_i) begin
            mem_q[waddr_i] <= wdata_i;
        end
    end

    assign rdata_a_o  = mem_q[raddr_a_i];
    assign rdata_b_o  = mem_q[raddr_b_i];
    assign dbg_data_o = mem_q[dbg_addr_i];

endmodule

// File: rtl/alu_regfile_ctrl.sv
// Three-cycle instruction issue stage: accept, execute through the external ALU, write back.
module alu_regfile_ctrl
    import alu_pkg::*;
#(
    parameter int WIDTH = 8,
    parameter int REGS  = 8
) (
    input  logic            clk,
    input  logic            rst_n,
    alu_regfile_ctrl_if.slave bus
);
    localparam int AW = $clog2(REGS);

    state_e           state_q, state_d;
    op_e              op_q;
    logic [AW-1:0]    rd_q, ra_q, rb_q;
    logic [WIDTH-1:0] imm_q, res_q;
    logic [2:0]       flags_q;
    logic             ready_q, ready_d;
    logic             wb_valid_q, wb_valid_d;
    logic             accept_s, we_s;
    logic [WIDTH-1:0] rd_a_s, rd_b_s;

    assign accept_s = ready_q && bus.instr_valid;

    regfile #(.WIDTH(WIDTH), .REGS(REGS), .AW(AW)) u_regfile (
        .clk        (clk),
        .rst_n      (rst_n),
        .we_i       (we_s),
        .waddr_i    (rd_q),
        .wdata_i    (res_q),
        .raddr_a_i  (ra_q),
        .rdata_a_o  (rd_a_s),
        .raddr_b_i  (rb_q),
        .rdata_b_o  (rd_b_s),
        .dbg_addr_i (bus.dbg_addr),
        .dbg_data_o (bus.dbg_data)
    );

    // State register plus registered handshake and write-back strobe.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= ST_IDLE;
            ready_q    <= 1'b0;
            wb_valid_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            ready_q    <= ready_d;
            wb_valid_q <= wb_valid_d;
        end
    end

    // Next-state logic.
    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE: begin
                if (accept_s) state_d = ST_EXEC;
                else          state_d = ST_IDLE;
            end
            ST_EXEC: state_d = ST_WB;
            ST_WB:   state_d = ST_IDLE;
            default: state_d = ST_IDLE;
        endcase
    end

    // Outputs: ready/strobe are pre-computed from the next state so they come out of flops.
    always_comb begin
        ready_d    = (state_d == ST_IDLE);
        wb_valid_d = (state_d == ST_WB);
        we_s       = (state_q == ST_WB);
        if (state_q == ST_EXEC) begin
            bus.alu_a = rd_a_s;
            bus.alu_b = rd_b_s;
        end else begin
            bus.alu_a = '0;
            bus.alu_b = '0;
        end
    end

    // Instruction latch, result capture and flag register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            op_q    <= OP_ADD;
            rd_q    <= '0;
            ra_q    <= '0;
            rb_q    <= '0;
            imm_q   <= '0;
            res_q   <= '0;
            flags_q <= 3'b000;
        end else begin
            if (accept_s) begin
                op_q  <= op_e'(bus.instr_op);
                rd_q  <= bus.instr_rd;
                ra_q  <= bus.instr_ra;
                rb_q  <= bus.instr_rb;
                imm_q <= bus.instr_imm;
            end
            if (state_q == ST_EXEC) begin
                if (op_q == OP_LOADI) begin
                    res_q <= imm_q;
                end else begin
                    res_q   <= bus.alu_y;
                    flags_q <= bus.alu_onz;
                end
            end
        end
    end

    assign bus.instr_ready = ready_q;
    assign bus.alu_op      = op_q;
    assign bus.flags       = flags_q;
    assign bus.wb_valid    = wb_valid_q;
    assign bus.wb_addr     = rd_q;
    assign bus.wb_data     = res_q;

endmodule

// File: tb/tb_alu_regfile_ctrl.sv
// Self-checking bench: issue stage plus ALU, checked against a plain-arithmetic reference model.
module tb_alu_regfile_ctrl;
    import alu_pkg::*;

    localparam int W  = 8;
    localparam int R  = 8;
    localparam int AW = 3;

    logic clk   = 1'b0;
    logic rst_n = 1'b1;
    always #5 clk = ~clk;

    alu_regfile_ctrl_if #(.WIDTH(W), .AW(AW)) bus ();

    alu_regfile_ctrl #(.WIDTH(W), .REGS(R)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    ALU #(.width(W)) u_alu (
        .A   (bus.alu_a),
        .B   (bus.alu_b),
        .op  (bus.alu_op),
        .Y   (bus.alu_y),
        .ONZ (bus.alu_onz)
    );

    int         checks = 0;
    int         errors = 0;
    logic [7:0] mrf [R];
    logic [2:0] mflags;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Reference: two's-complement arithmetic on ints, overflow = result outside [-128, 127].
    function automatic void ref_exec(input logic [2:0] op, input logic [7:0] a, input logic [7:0] b,
                                     output logic [7:0] y, output logic [2:0] f);
        int sa, sb, s;
        bit o;
        sa = $signed(a);
        sb = $signed(b);
        s  = 0;
        o  = 1'b0;
        case (op)
            3'd0: begin s = sa + sb; y = 8'(s); o = (s > 127) || (s < -128); end
            3'd1: begin s = sa - sb; y = 8'(s); o = (s > 127) || (s < -128); end
            3'd2: y = a & b;
            3'd3: y = a | b;
            3'd4: y = a ^ b;
            3'd5: y = ~a;
            3'd6: y = a;
            default: y = 8'h00;
        endcase
        f = {o, y[7], (y == 8'h00)};
    endfunction

    task automatic read_dbg(input string tag, input logic [2:0] addr, input logic [7:0] exp);
        bus.dbg_addr = addr;
        #1;
        check(tag, bus.dbg_data, exp);
    endtask

    task automatic run_instr(input logic [2:0] op, input logic [2:0] rd, input logic [2:0] ra,
                             input logic [2:0] rb, input logic [7:0] imm, input bit hold);
        logic [7:0] ey;
        logic [2:0] ef;
        int waited;
        bus.instr_op    = op;
        bus.instr_rd    = rd;
        bus.instr_ra    = ra;
        bus.instr_rb    = rb;
        bus.instr_imm   = imm;
        bus.instr_valid = 1'b1;
        waited = 0;
        while (!bus.instr_ready && waited < 20) begin
            @(posedge clk); #1;
            waited++;
        end
        check("ready_timeout", 32'(waited < 20), 32'd1);
        @(posedge clk); #1;
        if (!hold) bus.instr_valid = 1'b0;
        if (op == 3'b111) begin
            ey = imm;
            ef = mflags;
        end else begin
            ref_exec(op, mrf[ra], mrf[rb], ey, ef);
            check("exec_alu_a", bus.alu_a, mrf[ra]);
            check("exec_alu_b", bus.alu_b, mrf[rb]);
        end
        check("exec_ready", bus.instr_ready, 1'b0);
        check("exec_wb_valid", bus.wb_valid, 1'b0);
        @(posedge clk); #1;
        check("wb_valid", bus.wb_valid, 1'b1);
        check("wb_addr", bus.wb_addr, rd);
        check("wb_data", bus.wb_data, ey);
        check("wb_flags", bus.flags, ef);
        check("wb_ready", bus.instr_ready, 1'b0);
        mflags  = ef;
        mrf[rd] = ey;
        @(posedge clk); #1;
        check("idle_wb_valid", bus.wb_valid, 1'b0);
        check("idle_ready", bus.instr_ready, 1'b1);
        read_dbg("rf_write", rd, mrf[rd]);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not complete in time");
        $fatal(1, "watchdog");
    end

    initial begin
        for (int i = 0; i < R; i++) mrf[i] = 8'h00;
        mflags          = 3'b000;
        bus.instr_valid = 1'b0;
        bus.instr_op    = 3'b000;
        bus.instr_rd    = 3'd0;
        bus.instr_ra    = 3'd0;
        bus.instr_rb    = 3'd0;
        bus.instr_imm   = 8'h00;
        bus.dbg_addr    = 3'd0;
        #1 rst_n = 1'b0;

        // Reset with random input activity.
        for (int c = 0; c < 4; c++) begin
            @(posedge clk); #1;
            bus.instr_valid = 1'($urandom);
            bus.instr_op    = 3'($urandom);
            bus.instr_rd    = 3'($urandom);
            bus.instr_ra    = 3'($urandom);
            bus.instr_rb    = 3'($urandom);
            bus.instr_imm   = 8'($urandom);
        end
        #1;
        check("rst_ready", bus.instr_ready, 1'b0);
        check("rst_flags", bus.flags, 3'b000);
        check("rst_wb_valid", bus.wb_valid, 1'b0);
        check("rst_alu_op", bus.alu_op, 3'b000);
        for (int i = 0; i < R; i++) read_dbg("rst_rf", 3'(i), 8'h00);
        bus.instr_valid = 1'b0;
        @(posedge clk); #1;
        rst_n = 1'b1;
        check("post_rst_ready_low", bus.instr_ready, 1'b0);
        @(posedge clk); #1;
        check("post_rst_ready_high", bus.instr_ready, 1'b1);

        // Loads and a plain add; LOADI must leave flags alone.
        run_instr(3'b111, 3'd1, 3'd0, 3'd0, 8'h05, 1'b0);
        check("loadi_flags", bus.flags, 3'b000);
        run_instr(3'b111, 3'd2, 3'd0, 3'd0, 8'h03, 1'b0);
        run_instr(3'b000, 3'd3, 3'd1, 3'd2, 8'h00, 1'b0);
        read_dbg("add_r3", 3'd3, 8'h08);
        check("add_flags", bus.flags, 3'b000);

        run_instr(3'b001, 3'd4, 3'd2, 3'd1, 8'h00, 1'b0);
        read_dbg("sub_r4", 3'd4, 8'hFE);
        check("sub_flags", bus.flags, 3'b010);

        run_instr(3'b111, 3'd5, 3'd0, 3'd0, 8'h7F, 1'b0);
        run_instr(3'b111, 3'd6, 3'd0, 3'd0, 8'h01, 1'b0);
        run_instr(3'b000, 3'd7, 3'd5, 3'd6, 8'h00, 1'b0);
        read_dbg("ovf_r7", 3'd7, 8'h80);
        check("ovf_flags", bus.flags, 3'b110);
        run_instr(3'b100, 3'd7, 3'd7, 3'd7, 8'h00, 1'b0);
        read_dbg("xor_r7", 3'd7, 8'h00);
        check("xor_flags", bus.flags, 3'b001);

        // Back-to-back with valid held high.
        run_instr(3'b000, 3'd1, 3'd1, 3'd1, 8'h00, 1'b1);
        read_dbg("b2b_r1_first", 3'd1, 8'h0A);
        run_instr(3'b000, 3'd1, 3'd1, 3'd1, 8'h00, 1'b0);
        read_dbg("b2b_r1_second", 3'd1, 8'h14);

        // Reset during EXEC aborts the write.
        bus.instr_op    = 3'b000;
        bus.instr_rd    = 3'd3;
        bus.instr_ra    = 3'd1;
        bus.instr_rb    = 3'd2;
        bus.instr_valid = 1'b1;
        @(posedge clk); #1;
        bus.instr_valid = 1'b0;
        rst_n = 1'b0;
        #1;
        check("abort_flags", bus.flags, 3'b000);
        check("abort_ready", bus.instr_ready, 1'b0);
        for (int c = 0; c < 3; c++) begin
            @(posedge clk); #1;
            check("abort_wb_valid", bus.wb_valid, 1'b0);
        end
        rst_n = 1'b1;
        for (int i = 0; i < R; i++) mrf[i] = 8'h00;
        mflags = 3'b000;
        for (int c = 0; c < 2; c++) begin
            @(posedge clk); #1;
            check("abort_wb_valid_after", bus.wb_valid, 1'b0);
        end
        read_dbg("abort_r3", 3'd3, 8'h00);
        check("abort_flags_after", bus.flags, 3'b000);

        // Randomized instruction stream against the model.
        for (int n = 0; n < 60; n++) begin
            run_instr(3'($urandom), 3'($urandom), 3'($urandom), 3'($urandom),
                      8'($urandom), 1'($urandom_range(0, 1)));
        end
        bus.instr_valid = 1'b0;
        for (int i = 0; i < R; i++) read_dbg("final_rf", 3'(i), mrf[i]);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
